// File: rtl/det_gap_pkg.sv
// Shared constants for the detection gap logger.
//   DEPTH_DEFAULT : default FIFO depth (entries, power of two)
//   GAP_W_DEFAULT : default gap counter width in bits
//   GAP_MAX       : saturation value of a gap at the default width
package det_gap_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned GAP_W_DEFAULT = 8;
  localparam int unsigned GAP_MAX       = (1 << GAP_W_DEFAULT) - 1;

endpackage

// File: rtl/gap_fifo.sv
// Small synchronous FIFO holding measured gaps.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (clears pointers and count)
//   push_i  : write data_i; ignored when full unless a pop happens on the same edge
//   pop_i   : remove head; ignored when empty
//   data_i  : value to push
//   full_o  : occupancy == DEPTH
//   empty_o : occupancy == 0
//   count_o : current occupancy
//   head_o  : entry at the read pointer
module gap_fifo
  import det_gap_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = GAP_W_DEFAULT,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full buffer can still take a write when the head leaves on the same edge.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/det_gap_logger.sv
// Measures the distance in cycles between successive detection pulses and
// queues each distance for a downstream consumer.
//   CLK       : clock, rising edge
//   RST       : synchronous active-high reset, wins over DIN/OUT_READY
//   DIN       : detection pulse, one event per cycle sampled high
//   OUT_READY : consumer takes the head entry this cycle
//   OUT_VALID : FIFO non-empty
//   OUT_DATA  : gap at FIFO head
//   EVT_CNT   : events since reset, wraps at 256
//   OVF       : sticky, a gap was dropped because the FIFO was full
module det_gap_logger
  import det_gap_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned GAP_W = GAP_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [GAP_W-1:0] OUT_DATA,
  output logic [7:0]       EVT_CNT,
  output logic             OVF
);

  localparam int unsigned      CntW   = $clog2(DEPTH) + 1;
  localparam logic [GAP_W-1:0] GapMax = {GAP_W{1'b1}};

  logic             armed_q, armed_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       evt_cnt_q, evt_cnt_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;

  // The first event after reset only starts the measurement.
  assign push = DIN & armed_q;

  always_comb begin
    armed_d   = armed_q;
    gap_d     = gap_q;
    evt_cnt_d = evt_cnt_q;
    ovf_d     = ovf_q;
    if (DIN) begin
      armed_d   = 1'b1;
      gap_d     = GAP_W'(1);
      evt_cnt_d = evt_cnt_q + 8'd1;
    end else if (armed_q && gap_q != GapMax) begin
      gap_d = gap_q + GAP_W'(1);
    end
    // When full, the head is valid, so OUT_READY alone means a slot frees up.
    if (push && fifo_full && !OUT_READY) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      armed_q   <= 1'b0;
      gap_q     <= '0;
      evt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      gap_q     <= gap_d;
      evt_cnt_q <= evt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  gap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GAP_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (OUT_READY),
    .data_i  (gap_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (OUT_DATA)
  );

  // Full flag and occupancy must always agree.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (fifo_full == (fifo_count == CntW'(DEPTH)));
    end
  end

  assign OUT_VALID = ~fifo_empty;
  assign EVT_CNT   = evt_cnt_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_det_gap_logger.sv
module tb_det_gap_logger;
  import det_gap_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP_W = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             DIN = 1'b0;
  logic             OUT_READY = 1'b0;
  logic             OUT_VALID;
  logic [GAP_W-1:0] OUT_DATA;
  logic [7:0]       EVT_CNT;
  logic             OVF;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state; sb holds the gaps expected at the DUT output, in order.
  bit         m_armed = 1'b0;
  int         m_gap   = 0;
  logic [7:0] m_cnt   = 8'd0;
  bit         m_ovf   = 1'b0;
  int         sb[$];

  always #5 CLK = ~CLK;

  det_gap_logger #(
    .DEPTH (DEPTH),
    .GAP_W (GAP_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .OUT_READY (OUT_READY),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .EVT_CNT   (EVT_CNT),
    .OVF       (OVF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Compare outputs against the model at the falling edge, then drive the next
  // inputs and advance the model by the edge that is about to happen.
  task automatic step(input bit rst, input bit din, input bit rdy);
    bit pop;
    @(negedge CLK);
    chk("valid", 32'(OUT_VALID), 32'(sb.size() > 0));
    if (sb.size() > 0) chk("sb_data", 32'(OUT_DATA), sb[0]);
    chk("evt_cnt", 32'(EVT_CNT), 32'(m_cnt));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    RST       = rst;
    DIN       = din;
    OUT_READY = rdy;
    if (rst) begin
      m_armed = 1'b0;
      m_gap   = 0;
      m_cnt   = 8'd0;
      m_ovf   = 1'b0;
      sb.delete();
    end else begin
      pop = rdy && (sb.size() > 0);
      if (pop) void'(sb.pop_front());
      if (din) begin
        if (m_armed) begin
          if (sb.size() < DEPTH) sb.push_back(m_gap);
          else m_ovf = 1'b1;
        end
        m_armed = 1'b1;
        m_gap   = 1;
        m_cnt   = m_cnt + 8'd1;
      end else if (m_armed && m_gap < int'(GAP_MAX)) begin
        m_gap++;
      end
    end
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_d[3];

    // Reset, then events at cycles 10, 13, 14.
    step(1, 0, 0);
    step(1, 0, 0);
    for (int c = 0; c <= 16; c++) begin
      step(0, (c == 10 || c == 13 || c == 14), 0);
      if (c == 12) begin
        after_edge();
        chk("a_not_yet", 32'(OUT_VALID), 0);
      end
      if (c == 13) begin
        after_edge();
        chk("a_valid", 32'(OUT_VALID), 1);
        chk("a_gap3", 32'(OUT_DATA), 3);
      end
    end
    chk("a_evt_cnt", 32'(EVT_CNT), 3);
    step(0, 0, 1);
    after_edge();
    chk("a_gap1", 32'(OUT_DATA), 1);
    step(0, 0, 1);
    after_edge();
    chk("a_empty", 32'(OUT_VALID), 0);

    // Events 300 cycles apart saturate the gap.
    step(1, 0, 0);
    step(0, 1, 0);
    after_edge();
    chk("b_arm_only", 32'(OUT_VALID), 0);
    repeat (299) step(0, 0, 0);
    step(0, 1, 0);
    after_edge();
    chk("b_valid", 32'(OUT_VALID), 1);
    chk("b_sat", 32'(OUT_DATA), GAP_MAX);
    step(0, 0, 1);
    step(0, 0, 0);

    // Six gaps 1..6 with no consumer: first four kept, overflow sticky.
    step(1, 0, 0);
    step(0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      repeat (k - 1) step(0, 0, 0);
      step(0, 1, 0);
    end
    step(0, 0, 0);
    after_edge();
    chk("c_ovf", 32'(OVF), 1);
    chk("c_head", 32'(OUT_DATA), 1);
    for (int i = 2; i <= 4; i++) begin
      step(0, 0, 1);
      after_edge();
      chk("c_order", 32'(OUT_DATA), i);
    end
    step(0, 0, 1);
    after_edge();
    chk("c_drained", 32'(OUT_VALID), 0);
    chk("c_ovf_sticky", 32'(OVF), 1);

    // Full FIFO with push and pop on the same edge.
    step(1, 0, 0);
    step(0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (k - 1) step(0, 0, 0);
      step(0, 1, 0);
    end
    step(0, 0, 0);
    step(0, 1, 1);
    after_edge();
    chk("d_valid", 32'(OUT_VALID), 1);
    chk("d_ovf", 32'(OVF), 0);
    chk("d_head", 32'(OUT_DATA), 2);
    exp_d = '{3, 4, 2};
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      after_edge();
      chk("d_order", 32'(OUT_DATA), 32'(exp_d[i]));
    end
    step(0, 0, 1);
    after_edge();
    chk("d_drained", 32'(OUT_VALID), 0);

    // Reset mid-operation with DIN and OUT_READY high.
    step(1, 0, 0);
    step(0, 1, 0);
    repeat (5) step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    after_edge();
    chk("e_pre_ovf", 32'(OVF), 1);
    step(1, 1, 1);
    after_edge();
    chk("e_valid", 32'(OUT_VALID), 0);
    chk("e_cnt", 32'(EVT_CNT), 0);
    chk("e_ovf", 32'(OVF), 0);
    step(0, 1, 0);
    step(0, 0, 0);
    after_edge();
    chk("e_arm_only", 32'(OUT_VALID), 0);
    chk("e_cnt1", 32'(EVT_CNT), 1);
    step(0, 1, 0);
    after_edge();
    chk("e_gap2", 32'(OUT_DATA), 2);

    // Random traffic against the model.
    step(1, 0, 0);
    for (int i = 0; i < 128; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Event counter wraps 255 -> 0.
    step(1, 0, 0);
    repeat (260) step(0, 1, 1);
    step(0, 0, 1);
    after_edge();
    chk("g_wrap", 32'(EVT_CNT), 4);
    step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/det_gap_logger.md
DET_GAP_LOGGER -- requirements
Module: det_gap_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter GAP_W, default 8, meaning gap value width in bits.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-005 SHALL have port DIN  input  1  detection pulse from the upstream serial sequence detector's DOUT; one event per cycle sampled high.
REQ-006 SHALL have port OUT_READY  input  1  consumer accepts the head entry this cycle.
REQ-007 SHALL have port OUT_VALID  output  1  FIFO non-empty.
REQ-008 SHALL have port OUT_DATA  output  GAP_W  gap value at FIFO head.
REQ-009 SHALL have port EVT_CNT  output  8  total events seen since reset.
REQ-010 SHALL have port OVF  output  1  sticky flag: a gap was dropped because the FIFO was full.

Function
REQ-011 SHALL sample DIN only on rising CLK and treat each cycle with DIN=1 as one event; DIN changes between edges have no effect.
REQ-012 SHALL keep an ARMED bit (0 after reset) and a gap counter GAP (GAP_W bits).
REQ-013 SHALL, on an event with ARMED=0, set ARMED=1 and GAP=1, pushing nothing.
REQ-014 SHALL, on an event with ARMED=1, push the current GAP and then set GAP=1.
REQ-015 SHALL, on a non-event cycle with ARMED=1, set GAP=min(GAP+1, 2^GAP_W-1), saturating, never wrapping.
REQ-016 SHALL therefore push 1 for events on consecutive cycles and N for events N cycles apart (N capped at 2^GAP_W-1).
REQ-017 SHALL increment EVT_CNT by 1 per event, wrapping 255->0.
REQ-018 SHALL drive OUT_VALID=1 whenever occupancy>0 and OUT_DATA=head entry; OUT_DATA is don't-care when OUT_VALID=0.
REQ-019 SHALL pop the head on a rising edge where OUT_VALID=1 and OUT_READY=1; OUT_READY with OUT_VALID=0 has no effect.
REQ-020 SHALL preserve order (FIFO) and wrap read/write pointers modulo DEPTH.
REQ-021 SHALL, on a push with FIFO full and no pop in the same cycle, drop the new gap, keep contents unchanged, and set OVF=1.
REQ-022 SHALL, on a push and pop in the same cycle while full, accept both; occupancy stays DEPTH, OVF unchanged.
REQ-023 SHALL, on a push and pop in the same cycle while empty, push only; no pop occurs; OUT_VALID=1 next cycle.
REQ-024 SHALL keep OVF=1 until reset; popping does not clear it.
REQ-025 SHALL make a pushed value visible on OUT_DATA/OUT_VALID exactly one cycle after the event edge.

Reset
REQ-026 SHALL, when RST=1 at a rising edge, set ARMED=0, GAP=0, EVT_CNT=0, OVF=0, occupancy=0, pointers=0, so OUT_VALID=0 next cycle.
REQ-027 SHALL give RST priority over DIN and OUT_READY in the same cycle: the event is not counted, no push or pop occurs.
REQ-028 SHALL, after reset mid-operation, discard all buffered gaps; the first event after reset only arms.

Structure
REQ-029 SHALL place DEPTH default, GAP_W default, and the GAP_MAX constant (2^GAP_W-1) in a shared package det_gap_pkg.
REQ-030 SHALL implement the buffer as one sub-module gap_fifo (push/pop/full/empty/count/head), with the gap and event logic in det_gap_logger.

Verification
REQ-031 SHALL cover: reset, then DIN=1 at cycles 10, 13, 14 -> pushes 3, then 1; EVT_CNT=3; OUT_VALID rises one cycle after cycle 13.
REQ-032 SHALL cover: events 300 cycles apart with GAP_W=8 -> pushed value 255.
REQ-033 SHALL cover: OUT_READY=0, six gaps produced with DEPTH=4 -> FIFO holds first four in order; OVF=1; drained values match the first four.
REQ-034 SHALL cover: FIFO full, OUT_READY=1 and event on the same edge -> occupancy stays 4, OVF stays 0, head advances.
REQ-035 SHALL cover: RST=1 asserted with DIN=1 and 2 entries buffered -> next cycle OUT_VALID=0, EVT_CNT=0, OVF=0; next event only arms.
REQ-036 SHALL cover: 128 cycles of random DIN with random OUT_READY, checked against a scoreboard model of REQ-013..REQ-024.
